uiimx415_cfg_ctrl: RTL and testbench

UIIMX415_CFG_CTRL -- requirements
Module: uiimx415_cfg_ctrl

---
 rtl/uiimx415_cfg_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_uiimx415_cfg_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uiimx415_cfg_ctrl.sv
// IMX415 sensor configuration sequencer: power-up delay, register table walk over I2C, optional stream start.
// Latency: PWR_DLY cycles to LOAD, then LOAD/REQ/WAIT/NEXT per table entry (WAIT length set by the I2C master).
// Backpressure: O_iic_req is held off while I_iic_busy=1. NACKed writes are retried up to RETRY_MAX times, then ERR.
// Optional feature macro: UIIMX415_AUTO_STREAM_EN. When defined, the run writes 0x3000=0x00,
// waits STREAM_DLY cycles and writes 0x3002=0x00 after the last table entry.
// Ports: I_clk/I_rst_n clock and async active-low reset; I_start run trigger; O_reg_index/I_reg_data/I_reg_size
//        register table access; O_iic_* write request and I_iic_* master status; O_cfg_busy/done/err run status.
module uiimx415_cfg_ctrl #(
  parameter logic [6:0]  DEV_ADDR   = 7'h1A,
  parameter logic [23:0] PWR_DLY    = 24'd1_000_000,
  parameter logic [23:0] STREAM_DLY = 24'd500_000,
  parameter int          RETRY_MAX  = 3
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_start,
  output logic [8:0]  O_reg_index,
  input  logic [31:0] I_reg_data,
  input  logic [7:0]  I_reg_size,
  output logic        O_iic_req,
  output logic [6:0]  O_iic_dev,
  output logic [15:0] O_iic_addr,
  output logic [7:0]  O_iic_data,
  input  logic        I_iic_busy,
  input  logic        I_iic_done,
  input  logic        I_iic_nack,
  output logic        O_cfg_busy,
  output logic        O_cfg_done,
  output logic        O_cfg_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_PWR_WAIT, S_LOAD, S_REQ, S_WAIT, S_NEXT,
    S_STBY_REL, S_STRM_WAIT, S_MST_START, S_DONE, S_ERR
  } state_t;

  // The phase records which write is in flight, so WAIT knows where an ACK leads.
  localparam logic [1:0] PH_TBL  = 2'd0;
  localparam logic [1:0] PH_STBY = 2'd1;
  localparam logic [1:0] PH_MST  = 2'd2;

  localparam logic [7:0] RETRY_LIM = 8'(RETRY_MAX);

`ifdef UIIMX415_AUTO_STREAM_EN
  localparam state_t POST_TBL = S_STBY_REL;
`else
  localparam state_t POST_TBL = S_DONE;
`endif

  state_t      state_q, state_d;
  logic [23:0] dly_q, dly_d;
  logic [8:0]  idx_q, idx_d;
  logic [7:0]  retry_q, retry_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [1:0]  phase_q, phase_d;

  logic [8:0]  idx_inc;
  logic        pwr_last;
  logic        strm_last;
  logic        unused_reg_hi;

  assign idx_inc   = idx_q + 9'd1;
  // Widened compare so that a zero delay still leaves after one cycle instead of wrapping.
  assign pwr_last  = ({1'b0, dly_q} + 25'd1) >= {1'b0, PWR_DLY};
  assign strm_last = ({1'b0, dly_q} + 25'd1) >= {1'b0, STREAM_DLY};
  assign unused_reg_hi = ^I_reg_data[31:24];

  // State register
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (I_start) state_d = S_PWR_WAIT;
      S_PWR_WAIT:  if (pwr_last) state_d = (I_reg_size == 8'd0) ? POST_TBL : S_LOAD;
      S_LOAD:      state_d = S_REQ;
      S_REQ:       if (!I_iic_busy) state_d = S_WAIT;
      S_WAIT: begin
        if (I_iic_done) begin
          if (!I_iic_nack) begin
            case (phase_q)
              PH_STBY: state_d = S_STRM_WAIT;
              PH_MST:  state_d = S_DONE;
              default: state_d = S_NEXT;
            endcase
          end else if (retry_q < RETRY_LIM) begin
            state_d = S_REQ;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_NEXT:      state_d = (idx_inc == {1'b0, I_reg_size}) ? POST_TBL : S_LOAD;
      S_STBY_REL:  state_d = S_REQ;
      S_STRM_WAIT: if (strm_last) state_d = S_MST_START;
      S_MST_START: state_d = S_REQ;
      default:     state_d = S_IDLE;
    endcase
  end

  // Datapath next-state
  always_comb begin
    dly_d   = dly_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    addr_d  = addr_q;
    data_d  = data_q;
    phase_d = phase_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (I_start) begin
          dly_d   = 24'd0;
          idx_d   = 9'd0;
          retry_d = 8'd0;
          phase_d = PH_TBL;
        end
      end
      S_PWR_WAIT, S_STRM_WAIT: dly_d = dly_q + 24'd1;
      S_LOAD: begin
        addr_d = I_reg_data[23:8];
        data_d = I_reg_data[7:0];
      end
      S_WAIT: begin
        if (I_iic_done) begin
          if (!I_iic_nack)                retry_d = 8'd0;
          else if (retry_q < RETRY_LIM)   retry_d = retry_q + 8'd1;
        end
      end
      S_NEXT: idx_d = idx_inc;
      S_STBY_REL: begin
        addr_d  = 16'h3000;
        data_d  = 8'h00;
        phase_d = PH_STBY;
        dly_d   = 24'd0;
      end
      S_MST_START: begin
        addr_d  = 16'h3002;
        data_d  = 8'h00;
        phase_d = PH_MST;
      end
      default: ;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      dly_q   <= 24'd0;
      idx_q   <= 9'd0;
      retry_q <= 8'd0;
      addr_q  <= 16'd0;
      data_q  <= 8'd0;
      phase_q <= PH_TBL;
    end else begin
      dly_q   <= dly_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      phase_q <= phase_d;
    end
  end

  // Output logic. The request is gated by busy in the same cycle, so it can only pulse on the cycle that moves to WAIT.
  always_comb begin
    O_iic_req  = (state_q == S_REQ) && !I_iic_busy;
    O_cfg_busy = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
    O_cfg_done = (state_q == S_DONE);
    O_cfg_err  = (state_q == S_ERR);
  end

  assign O_iic_dev   = DEV_ADDR;
  assign O_iic_addr  = addr_q;
  assign O_iic_data  = data_q;
  assign O_reg_index = idx_q;

endmodule

// File: tb/tb_uiimx415_cfg_ctrl.sv
module tb_uiimx415_cfg_ctrl;

  localparam int PWR  = 10;
  localparam int STRM = 50;
`ifdef UIIMX415_AUTO_STREAM_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif

  logic        I_clk = 1'b0;
  logic        I_rst_n = 1'b0;
  logic        I_start = 1'b0;
  logic [8:0]  O_reg_index;
  logic [31:0] I_reg_data;
  logic [7:0]  I_reg_size = 8'd0;
  logic        O_iic_req;
  logic [6:0]  O_iic_dev;
  logic [15:0] O_iic_addr;
  logic [7:0]  O_iic_data;
  logic        I_iic_busy;
  logic        I_iic_done = 1'b0;
  logic        I_iic_nack = 1'b0;
  logic        O_cfg_busy, O_cfg_done, O_cfg_err;

  logic        busy_force = 1'b0;
  logic        mst_busy = 1'b0;
  assign I_iic_busy = busy_force | mst_busy;

  // Register table: entry i -> address 0x3000+i, value i+1.
  logic [15:0] tbl_addr;
  logic [7:0]  tbl_val;
  assign tbl_addr   = 16'h3000 + {7'd0, O_reg_index};
  assign tbl_val    = O_reg_index[7:0] + 8'h01;
  assign I_reg_data = {8'h00, tbl_addr, tbl_val};

  uiimx415_cfg_ctrl #(
    .DEV_ADDR  (7'h1A),
    .PWR_DLY   (24'(PWR)),
    .STREAM_DLY(24'(STRM)),
    .RETRY_MAX (3)
  ) dut (
    .I_clk      (I_clk),
    .I_rst_n    (I_rst_n),
    .I_start    (I_start),
    .O_reg_index(O_reg_index),
    .I_reg_data (I_reg_data),
    .I_reg_size (I_reg_size),
    .O_iic_req  (O_iic_req),
    .O_iic_dev  (O_iic_dev),
    .O_iic_addr (O_iic_addr),
    .O_iic_data (O_iic_data),
    .I_iic_busy (I_iic_busy),
    .I_iic_done (I_iic_done),
    .I_iic_nack (I_iic_nack),
    .O_cfg_busy (O_cfg_busy),
    .O_cfg_done (O_cfg_done),
    .O_cfg_err  (O_cfg_err)
  );

  always #5 I_clk = ~I_clk;

  int cyc = 0;
  always @(posedge I_clk) cyc++;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Request log and I2C master model (acts on falling edges).
  logic [15:0] log_addr[$];
  logic [7:0]  log_data[$];
  int          log_cyc[$];

  bit          mst_active = 1'b0;
  int          mst_cnt = 0;
  logic        cur_nack = 1'b0;
  logic        nack_en = 1'b0;
  logic [15:0] nack_addr = 16'h0;
  int          nack_times = 0;
  int          nack_given = 0;

  always @(negedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      mst_active = 1'b0;
      mst_busy   = 1'b0;
      I_iic_done = 1'b0;
      I_iic_nack = 1'b0;
      mst_cnt    = 0;
    end else begin
      if (O_iic_req === 1'b1) begin
        log_addr.push_back(O_iic_addr);
        log_data.push_back(O_iic_data);
        log_cyc.push_back(cyc);
      end
      I_iic_done = 1'b0;
      I_iic_nack = 1'b0;
      if (mst_active) begin
        mst_busy = 1'b1;
        if (mst_cnt == 0) begin
          I_iic_done = 1'b1;
          I_iic_nack = cur_nack;
          mst_active = 1'b0;
          mst_busy   = 1'b0;
        end else begin
          mst_cnt = mst_cnt - 1;
        end
      end else if (O_iic_req === 1'b1) begin
        mst_active = 1'b1;
        mst_cnt    = 2;
        cur_nack   = nack_en && (O_iic_addr == nack_addr) && (nack_given < nack_times);
        if (cur_nack) nack_given++;
      end
    end
  end

  function automatic int count_addr(input logic [15:0] a);
    int n = 0;
    foreach (log_addr[i]) if (log_addr[i] == a) n++;
    return n;
  endfunction

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
  endtask

  task automatic pulse_start(output int start_cyc);
    @(negedge I_clk);
    I_start = 1'b1;
    start_cyc = cyc;
    @(negedge I_clk);
    I_start = 1'b0;
  endtask

  task automatic wait_end(output bit timeout);
    timeout = 1'b1;
    for (int i = 0; i < 8000; i++) begin
      if (O_cfg_done === 1'b1 || O_cfg_err === 1'b1) begin
        timeout = 1'b0;
        break;
      end
      @(negedge I_clk);
    end
  endtask

  task automatic run_cfg(input logic [7:0] size, output bit timeout, output int start_cyc);
    I_reg_size = size;
    clear_log();
    pulse_start(start_cyc);
    wait_end(timeout);
  endtask

  task automatic test_reset();
    I_rst_n = 1'b0;
    repeat (3) @(negedge I_clk);
    chk_cnt++; if (O_iic_req !== 1'b0) $display("FAIL reset_req got %b want 0", O_iic_req); else pass_cnt++;
    chk_cnt++; if (O_reg_index !== 9'd0) $display("FAIL reset_index got %0d want 0", O_reg_index); else pass_cnt++;
    chk_cnt++; if (O_iic_addr !== 16'h0) $display("FAIL reset_addr got %h want 0000", O_iic_addr); else pass_cnt++;
    chk_cnt++; if (O_iic_data !== 8'h0) $display("FAIL reset_data got %h want 00", O_iic_data); else pass_cnt++;
    chk_cnt++; if ({O_cfg_busy, O_cfg_done, O_cfg_err} !== 3'b000) $display("FAIL reset_status got %b want 000", {O_cfg_busy, O_cfg_done, O_cfg_err}); else pass_cnt++;
    chk_cnt++; if (O_iic_dev !== 7'h1A) $display("FAIL dev_addr got %h want 1a", O_iic_dev); else pass_cnt++;
    I_rst_n = 1'b1;
    @(negedge I_clk);
  endtask

  task automatic test_full_run();
    bit to; int sc; int bad; int n;
    run_cfg(8'd201, to, sc);
    chk_cnt++; if (to) $display("FAIL full_timeout got timeout want done"); else pass_cnt++;
    chk_cnt++; if ({O_cfg_done, O_cfg_err, O_cfg_busy} !== 3'b100) $display("FAIL full_status got %b want 100", {O_cfg_done, O_cfg_err, O_cfg_busy}); else pass_cnt++;
    chk_cnt++; if (log_addr.size() != 201 + EXTRA) $display("FAIL full_count got %0d want %0d", log_addr.size(), 201 + EXTRA); else pass_cnt++;
    bad = 0;
    n = (log_addr.size() < 201) ? log_addr.size() : 201;
    for (int i = 0; i < n; i++)
      if (log_addr[i] !== 16'h3000 + 16'(i) || log_data[i] !== 8'(i + 1)) bad++;
    chk_cnt++; if (bad != 0 || n != 201) $display("FAIL full_order got %0d bad of %0d want 0 of 201", bad, n); else pass_cnt++;
    if (log_addr.size() > 0) begin
      chk_cnt++; if (log_addr[0] !== 16'h3000 || log_data[0] !== 8'h01) $display("FAIL first_entry got %h=%h want 3000=01", log_addr[0], log_data[0]); else pass_cnt++;
      chk_cnt++; if (log_cyc[0] - sc < PWR) $display("FAIL pwr_delay got %0d cycles want >= %0d", log_cyc[0] - sc, PWR); else pass_cnt++;
    end else begin
      chk_cnt++; $display("FAIL first_entry got no request want 3000=01");
    end
    chk_cnt++; if (O_reg_index !== 9'd201) $display("FAIL full_index got %0d want 201", O_reg_index); else pass_cnt++;
`ifdef UIIMX415_AUTO_STREAM_EN
    if (log_addr.size() == 203) begin
      chk_cnt++; if (log_addr[201] !== 16'h3000 || log_data[201] !== 8'h00) $display("FAIL stby_rel got %h=%h want 3000=00", log_addr[201], log_data[201]); else pass_cnt++;
      chk_cnt++; if (log_addr[202] !== 16'h3002 || log_data[202] !== 8'h00) $display("FAIL mst_start got %h=%h want 3002=00", log_addr[202], log_data[202]); else pass_cnt++;
      chk_cnt++; if (log_cyc[202] - log_cyc[201] < STRM) $display("FAIL stream_delay got %0d want >= %0d", log_cyc[202] - log_cyc[201], STRM); else pass_cnt++;
    end
`endif
  endtask

  task automatic test_retry();
    bit to; int sc;
    nack_en = 1'b1; nack_addr = 16'h3005; nack_times = 2; nack_given = 0;
    run_cfg(8'd10, to, sc);
    nack_en = 1'b0;
    chk_cnt++; if (to) $display("FAIL retry_timeout got timeout want done"); else pass_cnt++;
    chk_cnt++; if (count_addr(16'h3005) != 3) $display("FAIL retry_idx5 got %0d want 3", count_addr(16'h3005)); else pass_cnt++;
    chk_cnt++; if (log_addr.size() != 12 + EXTRA) $display("FAIL retry_total got %0d want %0d", log_addr.size(), 12 + EXTRA); else pass_cnt++;
    chk_cnt++; if ({O_cfg_done, O_cfg_err} !== 2'b10) $display("FAIL retry_status got %b want 10", {O_cfg_done, O_cfg_err}); else pass_cnt++;
    if (log_addr.size() > 8) begin
      chk_cnt++; if (log_addr[7] !== 16'h3005 || log_addr[8] !== 16'h3006) $display("FAIL retry_order got %h,%h want 3005,3006", log_addr[7], log_addr[8]); else pass_cnt++;
    end
  endtask

  task automatic test_err();
    bit to; int sc;
    nack_en = 1'b1; nack_addr = 16'h3007; nack_times = 4; nack_given = 0;
    run_cfg(8'd10, to, sc);
    nack_en = 1'b0;
    repeat (5) @(negedge I_clk);
    chk_cnt++; if (to) $display("FAIL err_timeout got timeout want err"); else pass_cnt++;
    chk_cnt++; if (count_addr(16'h3007) != 4) $display("FAIL err_idx7 got %0d want 4", count_addr(16'h3007)); else pass_cnt++;
    chk_cnt++; if (count_addr(16'h3008) != 0) $display("FAIL err_idx8 got %0d want 0", count_addr(16'h3008)); else pass_cnt++;
    chk_cnt++; if (log_addr.size() != 11) $display("FAIL err_total got %0d want 11", log_addr.size()); else pass_cnt++;
    chk_cnt++; if ({O_cfg_err, O_cfg_done, O_cfg_busy} !== 3'b100) $display("FAIL err_status got %b want 100", {O_cfg_err, O_cfg_done, O_cfg_busy}); else pass_cnt++;
  endtask

  task automatic test_busy_hold();
    bit to; int sc; int rel;
    I_reg_size = 8'd2;
    clear_log();
    busy_force = 1'b1;
    pulse_start(sc);
    chk_cnt++; if ({O_cfg_busy, O_cfg_err} !== 2'b10) $display("FAIL restart_status got %b want 10", {O_cfg_busy, O_cfg_err}); else pass_cnt++;
    repeat (12 + 20) @(negedge I_clk);
    chk_cnt++; if (log_addr.size() != 0) $display("FAIL busy_hold got %0d requests want 0", log_addr.size()); else pass_cnt++;
    busy_force = 1'b0;
    rel = cyc;
    wait_end(to);
    chk_cnt++; if (to) $display("FAIL busy_timeout got timeout want done"); else pass_cnt++;
    chk_cnt++; if (count_addr(16'h3000) != 1 + EXTRA / 2) $display("FAIL busy_pulse got %0d want %0d", count_addr(16'h3000), 1 + EXTRA / 2); else pass_cnt++;
    chk_cnt++; if (log_addr.size() != 2 + EXTRA) $display("FAIL busy_total got %0d want %0d", log_addr.size(), 2 + EXTRA); else pass_cnt++;
    if (log_cyc.size() > 0) begin
      chk_cnt++; if (log_cyc[0] < rel) $display("FAIL busy_release got cycle %0d want >= %0d", log_cyc[0], rel); else pass_cnt++;
    end
  endtask

  task automatic test_empty();
    bit to; int sc;
    run_cfg(8'd0, to, sc);
    chk_cnt++; if (to) $display("FAIL empty_timeout got timeout want done"); else pass_cnt++;
    chk_cnt++; if (log_addr.size() != EXTRA) $display("FAIL empty_count got %0d want %0d", log_addr.size(), EXTRA); else pass_cnt++;
    chk_cnt++; if (O_reg_index !== 9'd0) $display("FAIL empty_index got %0d want 0", O_reg_index); else pass_cnt++;
  endtask

  task automatic test_ignore_start();
    bit to; int sc; int sc2;
    I_reg_size = 8'd3;
    clear_log();
    pulse_start(sc);
    repeat (15) @(negedge I_clk);
    pulse_start(sc2);
    wait_end(to);
    chk_cnt++; if (to) $display("FAIL ign_timeout got timeout want done"); else pass_cnt++;
    chk_cnt++; if (log_addr.size() != 3 + EXTRA) $display("FAIL ign_total got %0d want %0d", log_addr.size(), 3 + EXTRA); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit to; int sc; bit found; int n;
    I_reg_size = 8'd201;
    clear_log();
    pulse_start(sc);
    found = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (count_addr(16'h3064) != 0) begin found = 1'b1; break; end
      @(negedge I_clk);
    end
    chk_cnt++; if (!found) $display("FAIL rst_mid_reach got no request for index 100 want one"); else pass_cnt++;
    @(negedge I_clk);
    #2 I_rst_n = 1'b0;
    #1;
    chk_cnt++; if (O_iic_req !== 1'b0 || O_reg_index !== 9'd0) $display("FAIL rst_mid_req_idx got %b/%0d want 0/0", O_iic_req, O_reg_index); else pass_cnt++;
    chk_cnt++; if (O_iic_addr !== 16'h0 || O_iic_data !== 8'h0) $display("FAIL rst_mid_addr got %h=%h want 0000=00", O_iic_addr, O_iic_data); else pass_cnt++;
    chk_cnt++; if ({O_cfg_busy, O_cfg_done, O_cfg_err} !== 3'b000) $display("FAIL rst_mid_status got %b want 000", {O_cfg_busy, O_cfg_done, O_cfg_err}); else pass_cnt++;
    n = log_addr.size();
    repeat (5) @(negedge I_clk);
    chk_cnt++; if (log_addr.size() != n) $display("FAIL rst_mid_quiet got %0d requests want %0d", log_addr.size(), n); else pass_cnt++;
    I_rst_n = 1'b1;
    @(negedge I_clk);
    run_cfg(8'd3, to, sc);
    chk_cnt++; if (to || O_cfg_done !== 1'b1) $display("FAIL rst_rerun got done=%b want 1", O_cfg_done); else pass_cnt++;
    if (log_addr.size() > 0) begin
      chk_cnt++; if (log_addr[0] !== 16'h3000 || log_data[0] !== 8'h01) $display("FAIL rst_rerun_first got %h=%h want 3000=01", log_addr[0], log_data[0]); else pass_cnt++;
    end
    chk_cnt++; if (log_addr.size() != 3 + EXTRA) $display("FAIL rst_rerun_total got %0d want %0d", log_addr.size(), 3 + EXTRA); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_retry();
    test_err();
    test_busy_hold();
    test_empty();
    test_ignore_start();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
